bitmap_alloc_ctrl: RTL and testbench

Allocation/release client for the `bit_map_rom` free-block bitmap.

- **Allocate:** accepts a request for N blocks, checks capacity, and pops N free block addresses one at a time. Each is claimed by writing 1 into bitmap write port 1, with a fixed pause for the bitmap pipeline to settle between claims.
- **Release:** freed block addresses are registered and written as 0 through bitmap write port 2.
- **Placement:** sits between the packet-buffer write controller (requester) and the bitmap.

---
 rtl/bitmap_pkg.sv | 15 +
 rtl/bitmap_alloc_ctrl_if.sv | 44 ++++
 rtl/bitmap_alloc_ctrl_rel_reg.sv | 32 +++
 rtl/bitmap_alloc_ctrl.sv | 117 +++++++++++
 tb/tb_bitmap_alloc_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitmap_pkg.sv
// Shared definitions for the free-block bitmap allocation client:
// default widths, allocator FSM states and the minimum bitmap settle time.
package bitmap_pkg;

   localparam int ADDR_W_DEF      = 10;
   localparam int LEN_W_DEF       = 6;
   localparam int REFRESH_LAT_MIN = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_FREE = 2'd1,
      ST_REFRESH   = 2'd2
   } allocState_t;

endpackage

// File: rtl/bitmap_alloc_ctrl_if.sv
// Request, release and bitmap-status signals of the allocation client.
// The slave view is the allocator; the master view is requester plus bitmap.
interface bitmap_alloc_ctrl_if
   import bitmap_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) ();

   logic              alloc_req_vld;
   logic [LEN_W-1:0]  alloc_req_len;
   logic              alloc_req_rdy;
   logic              alloc_nack;
   logic              alloc_addr_vld;
   logic [ADDR_W-1:0] alloc_addr;
   logic              alloc_addr_last;
   logic              rel_vld;
   logic [ADDR_W-1:0] rel_addr;
   logic [ADDR_W-1:0] emp_ready_addr;
   logic              emp_ready_vld;
   logic [ADDR_W:0]   emp_addr_num;
   logic              wr_en_1;
   logic [ADDR_W-1:0] wr_addr_1;
   logic              wr_val_1;
   logic              wr_en_2;
   logic [ADDR_W-1:0] wr_addr_2;
   logic              wr_val_2;
   logic              busy;

   modport slave (
      input  alloc_req_vld, alloc_req_len, rel_vld, rel_addr,
             emp_ready_addr, emp_ready_vld, emp_addr_num,
      output alloc_req_rdy, alloc_nack, alloc_addr_vld, alloc_addr, alloc_addr_last,
             wr_en_1, wr_addr_1, wr_val_1, wr_en_2, wr_addr_2, wr_val_2, busy
   );

   modport master (
      output alloc_req_vld, alloc_req_len, rel_vld, rel_addr,
             emp_ready_addr, emp_ready_vld, emp_addr_num,
      input  alloc_req_rdy, alloc_nack, alloc_addr_vld, alloc_addr, alloc_addr_last,
             wr_en_1, wr_addr_1, wr_val_1, wr_en_2, wr_addr_2, wr_val_2, busy
   );

endinterface

// File: rtl/bitmap_alloc_ctrl_rel_reg.sv
// Release path: one register stage turning a freed block address into a
// clear-bit write on the bitmap's second write port.
module bitmap_rel_reg
   import bitmap_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_relVld,
   input  logic [ADDR_W-1:0] i_relAddr,
   output logic              o_wrEn,
   output logic [ADDR_W-1:0] o_wrAddr
);

   logic              r_wrEn;
   logic [ADDR_W-1:0] r_wrAddr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrEn   <= 1'b0;
         r_wrAddr <= '0;
      end else begin
         r_wrEn   <= i_relVld;
         r_wrAddr <= i_relAddr;
      end
   end

   assign o_wrEn   = r_wrEn;
   assign o_wrAddr = r_wrAddr;

endmodule

// File: rtl/bitmap_alloc_ctrl.sv
// Allocation client for the free-block bitmap: claims N free blocks one at a
// time with a settle pause after each claim, and forwards releases.
module bitmap_alloc_ctrl
   import bitmap_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int LEN_W       = LEN_W_DEF,
   parameter int REFRESH_LAT = REFRESH_LAT_MIN
) (
   input  logic                clk,
   input  logic                rst,
   bitmap_alloc_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(REFRESH_LAT + 1);
   localparam int CMP_W = (LEN_W > ADDR_W + 1) ? LEN_W : ADDR_W + 1;

   allocState_t       r_state, w_stateNext;
   logic [LEN_W-1:0]  r_remaining, w_remainingNext;
   logic [CNT_W-1:0]  r_cnt, w_cntNext;
   logic              w_nack, w_claim, w_last, w_reject;
   logic              r_rdy, r_nack, r_addrVld, r_addrLast;
   logic [ADDR_W-1:0] r_addr;
   logic [CMP_W-1:0]  w_lenExt, w_numExt;

   // The free count is trustworthy only in IDLE, since no claim is in flight there.
   assign w_lenExt = CMP_W'(bus.alloc_req_len);
   assign w_numExt = CMP_W'(bus.emp_addr_num);
   assign w_reject = (bus.alloc_req_len == '0) || (w_lenExt > w_numExt);

   always_comb begin
      w_stateNext     = r_state;
      w_remainingNext = r_remaining;
      w_cntNext       = r_cnt;
      w_nack          = 1'b0;
      w_claim         = 1'b0;
      w_last          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.alloc_req_vld) begin
               if (w_reject) begin
                  w_nack = 1'b1;
               end else begin
                  w_remainingNext = bus.alloc_req_len;
                  w_stateNext     = ST_WAIT_FREE;
               end
            end
         end
         ST_WAIT_FREE: begin
            if (bus.emp_ready_vld) begin
               w_claim         = 1'b1;
               w_last          = (r_remaining == LEN_W'(1));
               w_remainingNext = r_remaining - LEN_W'(1);
               w_cntNext       = CNT_W'(REFRESH_LAT);
               w_stateNext     = ST_REFRESH;
            end
         end
         ST_REFRESH: begin
            w_cntNext = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_stateNext = (r_remaining != '0) ? ST_WAIT_FREE : ST_IDLE;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // Every handshake output is registered so the bitmap sees clean pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_cnt       <= '0;
         r_rdy       <= 1'b0;
         r_nack      <= 1'b0;
         r_addrVld   <= 1'b0;
         r_addrLast  <= 1'b0;
         r_addr      <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_remaining <= w_remainingNext;
         r_cnt       <= w_cntNext;
         r_rdy       <= (w_stateNext == ST_IDLE);
         r_nack      <= w_nack;
         r_addrVld   <= w_claim;
         r_addrLast  <= w_last;
         if (w_claim) begin
            r_addr <= bus.emp_ready_addr;
         end
      end
   end

   assign bus.alloc_req_rdy   = r_rdy;
   assign bus.alloc_nack      = r_nack;
   assign bus.alloc_addr_vld  = r_addrVld;
   assign bus.alloc_addr      = r_addr;
   assign bus.alloc_addr_last = r_addrLast;
   assign bus.wr_en_1         = r_addrVld;
   assign bus.wr_addr_1       = r_addr;
   assign bus.wr_val_1        = 1'b1;
   assign bus.wr_val_2        = 1'b0;
   assign bus.busy            = (r_state != ST_IDLE);

   bitmap_rel_reg #(
      .ADDR_W (ADDR_W)
   ) u_relReg (
      .clk       (clk),
      .rst       (rst),
      .i_relVld  (bus.rel_vld),
      .i_relAddr (bus.rel_addr),
      .o_wrEn    (bus.wr_en_2),
      .o_wrAddr  (bus.wr_addr_2)
   );

endmodule

// File: tb/tb_bitmap_alloc_ctrl.sv
// Bench for bitmap_alloc_ctrl against a 1024-block behavioural bitmap and a
// set-based reference of which blocks should be allocated.
module tb_bitmap_alloc_ctrl;

   localparam int LAT    = 3;
   localparam int NBLK   = 1024;
   localparam int PERIOD = LAT + 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bitmap_alloc_ctrl_if #(.ADDR_W(10), .LEN_W(6)) bus ();

   bitmap_alloc_ctrl #(
      .ADDR_W      (10),
      .LEN_W       (6),
      .REFRESH_LAT (LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural bitmap: 1 = allocated, lowest free address and free count are live.
   logic [NBLK-1:0] envBits;
   logic            envStall;
   logic            numOverrideEn;
   logic [10:0]     numOverrideVal;
   int              envCount;
   int              envLowest;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         envBits <= '0;
      end else begin
         if (bus.wr_en_1) envBits[bus.wr_addr_1] <= bus.wr_val_1;
         if (bus.wr_en_2) envBits[bus.wr_addr_2] <= bus.wr_val_2;
      end
   end

   always_comb begin
      envCount  = 0;
      envLowest = -1;
      for (int i = NBLK - 1; i >= 0; i--) begin
         if (!envBits[i]) begin
            envCount++;
            envLowest = i;
         end
      end
   end

   assign bus.emp_ready_addr = 10'(envLowest);
   assign bus.emp_ready_vld  = (envCount != 0) && !envStall;
   assign bus.emp_addr_num   = numOverrideEn ? numOverrideVal : 11'(envCount);

   // Reference: the set of blocks that should be allocated.
   logic [NBLK-1:0] refAlloc;
   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   function automatic int refLowestFree();
      for (int i = 0; i < NBLK; i++) begin
         if (!refAlloc[i]) return i;
      end
      return -1;
   endfunction

   function automatic int refFreeCount();
      int n = 0;
      for (int i = 0; i < NBLK; i++) begin
         if (!refAlloc[i]) n++;
      end
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".rdy"},     32'(bus.alloc_req_rdy), 0);
      checkOutput({tag, ".nack"},    32'(bus.alloc_nack), 0);
      checkOutput({tag, ".addrVld"}, 32'(bus.alloc_addr_vld), 0);
      checkOutput({tag, ".addr"},    32'(bus.alloc_addr), 0);
      checkOutput({tag, ".last"},    32'(bus.alloc_addr_last), 0);
      checkOutput({tag, ".wrEn1"},   32'(bus.wr_en_1), 0);
      checkOutput({tag, ".wrAddr1"}, 32'(bus.wr_addr_1), 0);
      checkOutput({tag, ".wrEn2"},   32'(bus.wr_en_2), 0);
      checkOutput({tag, ".wrAddr2"}, 32'(bus.wr_addr_2), 0);
      checkOutput({tag, ".busy"},    32'(bus.busy), 0);
   endtask

   task automatic checkBitmap(input string tag);
      checkOutput({tag, ".freeCount"},  32'(envCount), 32'(refFreeCount()));
      checkOutput({tag, ".lowestFree"}, 32'(envLowest), 32'(refLowestFree()));
   endtask

   // Issue a request at the current cycle T and check every cycle until rdy returns.
   task automatic applyStimulus(input int len, input bit keepVld, input int relAddr);
      int  avail;
      bit  accept;
      int  expAddr[$];
      int  n;
      int  k;
      int  a;
      avail  = numOverrideEn ? int'(numOverrideVal) : refFreeCount();
      accept = (len != 0) && (len <= avail);
      checkOutput("rdyBeforeReq", 32'(bus.alloc_req_rdy), 1);
      if (accept) begin
         for (int i = 0; i < len; i++) begin
            a = refLowestFree();
            expAddr.push_back(a);
            refAlloc[a] = 1'b1;
         end
      end
      bus.alloc_req_vld = 1'b1;
      bus.alloc_req_len = 6'(len);
      if (!accept) begin
         @(negedge clk);
         bus.alloc_req_vld = 1'b0;
         checkOutput("nackPulse", 32'(bus.alloc_nack), 1);
         checkOutput("nackRdy",   32'(bus.alloc_req_rdy), 1);
         checkOutput("nackNoWr",  32'(bus.wr_en_1), 0);
         checkOutput("nackIdle",  32'(bus.busy), 0);
         @(negedge clk);
         checkOutput("nackOneCycle", 32'(bus.alloc_nack), 0);
         checkOutput("nackNoAddr",   32'(bus.alloc_addr_vld), 0);
      end else begin
         n = len * PERIOD + 1;
         for (int d = 1; d <= n; d++) begin
            @(negedge clk);
            if (d == 1) begin
               if (!keepVld) bus.alloc_req_vld = 1'b0;
               if (relAddr >= 0) begin
                  bus.rel_vld  = 1'b1;
                  bus.rel_addr = 10'(relAddr);
               end
            end
            if (d == 2 && relAddr >= 0) begin
               bus.rel_vld = 1'b0;
               checkOutput("relWrEn2",   32'(bus.wr_en_2), 1);
               checkOutput("relWrAddr2", 32'(bus.wr_addr_2), 32'(relAddr));
               checkOutput("relWrVal2",  32'(bus.wr_val_2), 0);
               refAlloc[relAddr] = 1'b0;
            end
            if (d >= 2 && (d - 2) % PERIOD == 0) begin
               k = (d - 2) / PERIOD;
               checkOutput("claimVld",    32'(bus.alloc_addr_vld), 1);
               checkOutput("claimAddr",   32'(bus.alloc_addr), 32'(expAddr[k]));
               checkOutput("claimLast",   32'(bus.alloc_addr_last), 32'(k == len - 1));
               checkOutput("claimWrEn1",  32'(bus.wr_en_1), 1);
               checkOutput("claimWrAddr", 32'(bus.wr_addr_1), 32'(expAddr[k]));
               checkOutput("claimWrVal1", 32'(bus.wr_val_1), 1);
            end else begin
               checkOutput("noClaim", 32'({bus.alloc_addr_vld, bus.wr_en_1}), 0);
            end
            checkOutput("rdyTiming", 32'(bus.alloc_req_rdy), 32'(d == n));
         end
      end
   endtask

   task automatic doRelease(input int addr);
      bus.rel_vld  = 1'b1;
      bus.rel_addr = 10'(addr);
      @(negedge clk);
      bus.rel_vld = 1'b0;
      checkOutput("idleRelWrEn2",   32'(bus.wr_en_2), 1);
      checkOutput("idleRelWrAddr2", 32'(bus.wr_addr_2), 32'(addr));
      checkOutput("idleRelWrVal2",  32'(bus.wr_val_2), 0);
      refAlloc[addr] = 1'b0;
      @(negedge clk);
      checkOutput("idleRelOneCycle", 32'(bus.wr_en_2), 0);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput("idleRdy", 32'(bus.alloc_req_rdy), 1);
         checkOutput("idleNoClaim", 32'(bus.alloc_addr_vld), 0);
      end
   endtask

   initial begin
      int numBefore;
      int expA;
      int len;
      int q[$];
      rst               = 1'b1;
      refAlloc          = '0;
      envStall          = 1'b0;
      numOverrideEn     = 1'b0;
      numOverrideVal    = '0;
      bus.alloc_req_vld = 1'b0;
      bus.alloc_req_len = '0;
      bus.rel_vld       = 1'b0;
      bus.rel_addr      = '0;

      @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      #1;
      checkOutput("rdyAtRelease", 32'(bus.alloc_req_rdy), 0);
      @(negedge clk);
      checkOutput("rdyAfterReset", 32'(bus.alloc_req_rdy), 1);

      $display("[TB] empty bitmap, len=3");
      applyStimulus(3, 1'b0, -1);
      checkOutput("numAfterFirst", 32'(bus.emp_addr_num), 1021);
      checkBitmap("first");

      $display("[TB] rejects: short capacity and zero length");
      numOverrideEn  = 1'b1;
      numOverrideVal = 11'd2;
      applyStimulus(3, 1'b0, -1);
      applyStimulus(0, 1'b0, -1);
      numOverrideEn = 1'b0;
      checkBitmap("afterNack");

      $display("[TB] release in idle then reuse");
      applyStimulus(5, 1'b0, -1);
      doRelease(3);
      idleCycles(4);
      applyStimulus(1, 1'b0, -1);
      checkBitmap("reuse");

      $display("[TB] release coinciding with claim");
      applyStimulus(1, 1'b0, -1);
      numBefore = envCount;
      applyStimulus(1, 1'b0, 5);
      checkOutput("netNumUnchanged", 32'(bus.emp_addr_num), 32'(numBefore));
      checkOutput("bit5Clear", 32'(envBits[5]), 0);
      checkOutput("bit9Set",   32'(envBits[9]), 1);
      checkBitmap("coincide");

      $display("[TB] back-to-back with vld held high");
      applyStimulus(3, 1'b1, -1);
      applyStimulus(2, 1'b0, -1);
      checkBitmap("backToBack");

      $display("[TB] stalled bitmap");
      envStall = 1'b1;
      expA = refLowestFree();
      refAlloc[expA] = 1'b1;
      bus.alloc_req_vld = 1'b1;
      bus.alloc_req_len = 6'd1;
      @(negedge clk);
      bus.alloc_req_vld = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("stallNoClaim", 32'(bus.alloc_addr_vld), 0);
         checkOutput("stallBusy", 32'(bus.busy), 1);
      end
      envStall = 1'b0;
      @(negedge clk);
      checkOutput("stallClaimVld",  32'(bus.alloc_addr_vld), 1);
      checkOutput("stallClaimAddr", 32'(bus.alloc_addr), 32'(expA));
      repeat (3) @(negedge clk);
      checkOutput("stallRdyBack", 32'(bus.alloc_req_rdy), 1);
      checkBitmap("stall");

      $display("[TB] reset during refresh");
      expA = refLowestFree();
      bus.alloc_req_vld = 1'b1;
      bus.alloc_req_len = 6'd4;
      @(negedge clk);
      bus.alloc_req_vld = 1'b0;
      @(negedge clk);
      checkOutput("preResetClaim", 32'(bus.alloc_addr), 32'(expA));
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkAllZero("midReset");
      refAlloc = '0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rdyLowAtRelease", 32'(bus.alloc_req_rdy), 0);
      @(negedge clk);
      checkOutput("rdyAfterMidReset", 32'(bus.alloc_req_rdy), 1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checkOutput("noClaimAfterReset", 32'({bus.alloc_addr_vld, bus.wr_en_1}), 0);
      end
      checkBitmap("afterReset");

      $display("[TB] randomized requests and releases");
      for (int it = 0; it < 10; it++) begin
         if ($urandom_range(1, 0) == 1) begin
            q.delete();
            for (int i = 0; i < NBLK; i++) begin
               if (refAlloc[i]) q.push_back(i);
            end
            if (q.size() > 0) begin
               doRelease(q[$urandom_range(q.size() - 1, 0)]);
            end
         end
         len = int'($urandom_range(6, 0));
         applyStimulus(len, 1'b0, -1);
         checkBitmap("random");
         idleCycles(int'($urandom_range(2, 0)));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
